// File: rtl/instruction_queue.sv
// ============================================================================
// Module   : instruction_queue
// Purpose  : Circular FIFO between fetch and decode with a registered output
//            stage, sticky overflow flag and an early stall to fetch.
//            Optional latency-1 bypass when empty: INSTRUCTION_QUEUE_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_queue #(
  parameter int instructionSize = 32,
  parameter int addressSize     = 64,
  parameter int queueDepth      = 8,
  parameter int queueIndexSize  = 3
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic                      flushPipeline_i,
  input  logic                      enable_i,
  input  logic [0:instructionSize-1] instruction_i,
  input  logic [0:addressSize-1]     instructionAddress_i,
  input  logic                      decodeStall_i,
  output logic                      stall_o,
  output logic                      enable_o,
  output logic [0:instructionSize-1] instruction_o,
  output logic [0:addressSize-1]     instructionAddress_o,
  output logic [0:queueIndexSize]    count_o,
  output logic                      overflow_o
);

  localparam logic [queueIndexSize:0]   c_depth      = (queueIndexSize+1)'(queueDepth);
  localparam logic [queueIndexSize:0]   c_stallLevel = (queueIndexSize+1)'(queueDepth - 1);
  localparam logic [queueIndexSize:0]   c_countOne   = (queueIndexSize+1)'(1);
  localparam logic [queueIndexSize-1:0] c_ptrOne     = (queueIndexSize)'(1);

  logic [0:instructionSize-1] r_instrMem [queueDepth];
  logic [0:addressSize-1]     r_addrMem  [queueDepth];

  logic [queueIndexSize-1:0]  r_head;
  logic [queueIndexSize-1:0]  r_tail;
  logic [queueIndexSize:0]    r_count;
  logic                       r_overflow;
  logic                       r_enableOut;
  logic [0:instructionSize-1] r_instrOut;
  logic [0:addressSize-1]     r_addrOut;

  logic                       w_pop;
  logic                       w_push;
  logic                       w_bypass;
  logic                       w_write;
  logic                       w_drop;
  logic [queueIndexSize:0]    w_countNext;

  assign w_pop  = (r_count != '0) && !decodeStall_i;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign w_push = enable_i && ((r_count != c_depth) || w_pop);
  assign w_drop = enable_i && !w_push;

`ifdef INSTRUCTION_QUEUE_BYPASS_EN
  assign w_bypass = enable_i && (r_count == '0) && !decodeStall_i && !flushPipeline_i;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_write = w_push && !w_bypass && !flushPipeline_i;

  always_comb begin
    w_countNext = r_count;
    if (w_write && !w_pop) begin
      w_countNext = r_count + c_countOne;
    end else if (!w_write && w_pop) begin
      w_countNext = r_count - c_countOne;
    end
  end

  // Storage contents need no reset; validity is tracked by the pointers.
  always_ff @(posedge clock_i) begin
    if (w_write) begin
      r_instrMem[r_tail] <= instruction_i;
      r_addrMem[r_tail]  <= instructionAddress_i;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (flushPipeline_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_write) begin
        r_tail <= r_tail + c_ptrOne;
      end
      if (w_pop) begin
        r_head <= r_head + c_ptrOne;
      end
      r_count <= w_countNext;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_enableOut <= 1'b0;
      r_instrOut  <= '0;
      r_addrOut   <= '0;
    end else if (flushPipeline_i) begin
      r_enableOut <= 1'b0;
    end else if (w_bypass) begin
      r_enableOut <= 1'b1;
      r_instrOut  <= instruction_i;
      r_addrOut   <= instructionAddress_i;
    end else if (w_pop) begin
      r_enableOut <= 1'b1;
      r_instrOut  <= r_instrMem[r_head];
      r_addrOut   <= r_addrMem[r_head];
    end else begin
      r_enableOut <= 1'b0;
    end
  end

  // Asserting one entry early covers the instruction fetch has in flight.
  assign stall_o              = (r_count >= c_stallLevel);
  assign enable_o             = r_enableOut;
  assign instruction_o        = r_instrOut;
  assign instructionAddress_o = r_addrOut;
  assign count_o              = r_count;
  assign overflow_o           = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_instruction_queue.sv
// Self-checking bench for instruction_queue: vector table, directed corner
// sequences and a randomized run against a queue-based reference model.
`default_nettype none

module tb_instruction_queue;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset_i = 1'b0;
  logic        flush = 1'b0;
  logic        en = 1'b0;
  logic [0:31] instr = '0;
  logic [0:63] addr = '0;
  logic        dstall = 1'b0;
  logic        stall_o;
  logic        enable_o;
  logic [0:31] instruction_o;
  logic [0:63] instructionAddress_o;
  logic [0:3]  count_o;
  logic        overflow_o;

  int checks = 0;
  int errors = 0;

  instruction_queue dut (
    .clock_i(clk),
    .reset_i(reset_i),
    .flushPipeline_i(flush),
    .enable_i(en),
    .instruction_i(instr),
    .instructionAddress_i(addr),
    .decodeStall_i(dstall),
    .stall_o(stall_o),
    .enable_o(enable_o),
    .instruction_o(instruction_o),
    .instructionAddress_o(instructionAddress_o),
    .count_o(count_o),
    .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset_i = 1'b1; flush = 1'b0; en = 1'b0; dstall = 1'b0;
    tick();
    reset_i = 1'b0;
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] ins;
    logic [63:0] adr;
  } entry_t;

  entry_t      mq[$];
  logic        mEn = 1'b0;
  logic [31:0] mIns = '0;
  logic [63:0] mAdr = '0;
  logic        mOvf = 1'b0;

  task automatic modelStep();
    entry_t e;
    logic   doPop;
    logic   bypass;
    if (reset_i) begin
      mq.delete(); mEn = 1'b0; mIns = '0; mAdr = '0; mOvf = 1'b0;
    end else if (flush) begin
      mq.delete(); mEn = 1'b0;
    end else begin
      doPop  = (mq.size() > 0) && !dstall;
      bypass = 1'b0;
`ifdef INSTRUCTION_QUEUE_BYPASS_EN
      bypass = (mq.size() == 0) && en && !dstall;
`endif
      if (bypass) begin
        mEn = 1'b1; mIns = instr; mAdr = addr;
      end else if (doPop) begin
        e = mq.pop_front();
        mEn = 1'b1; mIns = e.ins; mAdr = e.adr;
      end else begin
        mEn = 1'b0;
      end
      if (en && !bypass) begin
        if (mq.size() < DEPTH) mq.push_back({instr, addr});
        else mOvf = 1'b1;
      end
    end
  endtask

  task automatic modelCycle();
    tick();
    modelStep();
    check("rnd_count", 64'(count_o), 64'(mq.size()));
    check("rnd_enable", 64'(enable_o), 64'(mEn));
    check("rnd_stall", 64'(stall_o), 64'(mq.size() >= DEPTH - 1));
    check("rnd_overflow", 64'(overflow_o), 64'(mOvf));
    check("rnd_instr", 64'(instruction_o), 64'(mIns));
    check("rnd_addr", 64'(instructionAddress_o), mAdr);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        en;
    logic        dstall;
    logic [31:0] ins;
    logic [63:0] adr;
    int          expCount;
    logic        expEn;
    logic        expStall;
    logic        expOvf;
    logic [63:0] expAdr;
  } vec_t;

  vec_t vt[19];

  initial begin
    // Fill eight entries under stall, overflow on the ninth, then push/pop at
    // full, drain, and confirm the outputs hold once enable_o drops.
    for (int i = 0; i < 8; i++)
      vt[i] = '{1'b1, 1'b1, 32'hA000_0000 + 32'(i), 64'h1000 + 64'(4 * i), i + 1, 1'b0, (i + 1 >= 7), 1'b0, 64'h0};
    vt[8]  = '{1'b1, 1'b1, 32'hDEAD_0000, 64'h1020, 8, 1'b0, 1'b1, 1'b1, 64'h0};
    vt[9]  = '{1'b1, 1'b0, 32'hB000_0000, 64'h2000, 8, 1'b1, 1'b1, 1'b1, 64'h1000};
    for (int i = 10; i < 17; i++)
      vt[i] = '{1'b0, 1'b0, 32'h0, 64'h0, 17 - i, 1'b1, (17 - i >= 7), 1'b1, 64'h1000 + 64'(4 * (i - 9))};
    vt[17] = '{1'b0, 1'b0, 32'h0, 64'h0, 0, 1'b1, 1'b0, 1'b1, 64'h2000};
    vt[18] = '{1'b0, 1'b0, 32'h0, 64'h0, 0, 1'b0, 1'b0, 1'b1, 64'h2000};

    // Reset state
    doReset();
    check("reset_count", 64'(count_o), 64'd0);
    check("reset_enable", 64'(enable_o), 64'd0);
    check("reset_overflow", 64'(overflow_o), 64'd0);
    check("reset_stall", 64'(stall_o), 64'd0);
    check("reset_instr", 64'(instruction_o), 64'd0);
    check("reset_addr", 64'(instructionAddress_o), 64'd0);

    // Single instruction latency
    en = 1'b1; instr = 32'h3821_0004; addr = 64'h1000; dstall = 1'b0;
    tick();
    en = 1'b0;
`ifdef INSTRUCTION_QUEUE_BYPASS_EN
    check("lat_enable_c1", 64'(enable_o), 64'd1);
    check("lat_instr_c1", 64'(instruction_o), 64'h3821_0004);
    check("lat_addr_c1", 64'(instructionAddress_o), 64'h1000);
    check("lat_count_c1", 64'(count_o), 64'd0);
    tick();
    check("lat_enable_c2", 64'(enable_o), 64'd0);
`else
    check("lat_enable_c1", 64'(enable_o), 64'd0);
    check("lat_count_c1", 64'(count_o), 64'd1);
    tick();
    check("lat_enable_c2", 64'(enable_o), 64'd1);
    check("lat_instr_c2", 64'(instruction_o), 64'h3821_0004);
    check("lat_addr_c2", 64'(instructionAddress_o), 64'h1000);
    check("lat_count_c2", 64'(count_o), 64'd0);
    tick();
    check("lat_enable_c3", 64'(enable_o), 64'd0);
`endif

    // Vector table
    doReset();
    for (int i = 0; i < 19; i++) begin
      en = vt[i].en; dstall = vt[i].dstall; instr = vt[i].ins; addr = vt[i].adr;
      tick();
      check($sformatf("vec%0d_count", i), 64'(count_o), 64'(vt[i].expCount));
      check($sformatf("vec%0d_enable", i), 64'(enable_o), 64'(vt[i].expEn));
      check($sformatf("vec%0d_stall", i), 64'(stall_o), 64'(vt[i].expStall));
      check($sformatf("vec%0d_overflow", i), 64'(overflow_o), 64'(vt[i].expOvf));
      check($sformatf("vec%0d_addr", i), 64'(instructionAddress_o), vt[i].expAdr);
    end
    en = 1'b0;

    // Flush with a concurrent push at count 5
    doReset();
    dstall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      en = 1'b1; addr = 64'h1000 + 64'(4 * i); instr = 32'(i);
      tick();
    end
    check("flush_pre_count", 64'(count_o), 64'd5);
    flush = 1'b1; en = 1'b1; addr = 64'h3000; instr = 32'h3000;
    tick();
    flush = 1'b0; en = 1'b0; dstall = 1'b0;
    check("flush_count", 64'(count_o), 64'd0);
    check("flush_enable", 64'(enable_o), 64'd0);
    check("flush_overflow", 64'(overflow_o), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("flush_no_emit", 64'(enable_o), 64'd0);
    end

    // Randomized run with the reference model; stall toggles every 3 cycles
    // early on to force wrap-around, then random stalls, flushes and a reset.
    reset_i = 1'b1; flush = 1'b0; en = 1'b0; dstall = 1'b0;
    modelCycle();
    reset_i = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (c < 60) dstall = ((c / 3) % 2) == 1;
      else dstall = ($urandom_range(0, 3) == 0);
      en      = ($urandom_range(0, 3) != 0);
      instr   = $urandom;
      addr    = {$urandom, $urandom};
      flush   = (c >= 60) && ($urandom_range(0, 39) == 0);
      reset_i = (c == 250);
      modelCycle();
    end
    reset_i = 1'b0; flush = 1'b0; en = 1'b0; dstall = 1'b0;
    for (int c = 0; c < DEPTH + 2; c++) modelCycle();
    check("final_drained", 64'(mq.size()), 64'(count_o));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
